top_level: RTL and testbench
============================

// Module: top_level
// PURPOSE
//  Tiny fixed-weight GAN datapath: a generator maps a 2-element latent (in_1, in_2)
//  to a 3x3 image (cross / circle), and a discriminator scores the stored image.
//  Q8.24 signed fixed point throughout; one MAC per cycle, weights hard-wired.
//  Top of the design; the FSM selects the operation from choice.
// PARAMETERS
//  WIDTH  32  data width of all inputs/outputs; FRAC = WIDTH-8 = 24 fraction bits (only 32 is supported)
// PORTS
//  clk                 in   1      single clock, all state updates on rising edge
//  rst                 in   1      synchronous, active-high reset
//  choice              in   1      operation select when idle: 1 = generate, 0 = discriminate
//  in_1                in   WIDTH  latent 0 (cross weight), signed Q8.24
//  in_2                in   WIDTH  latent 1 (circle weight), signed Q8.24
//  gen_finish          out  1      1-cycle pulse: generator finished, pixels valid
//  disc_finish         out  1      1-cycle pulse: discriminator finished, score valid
//  out_discriminator   out  WIDTH  discriminator score, Q8.24, in [0, 1.0]
//  pixel_RxC (R,C=1..3) out WIDTH  image pixels, Q8.24, in [0, 1.0]; nine ports pixel_1x1..pixel_3x3
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, accumulator 0, all pixels 0, out_discriminator 0,
//    gen_finish=disc_finish=0. Reset mid-operation aborts it; partial results are discarded.
//  - States: IDLE, GEN, DISC, DFIN. Index k=0..8 row-major (k=3*(R-1)+(C-1)).
//  - IDLE: choice is sampled every edge (level, not edge). choice=1 -> GEN, k<=0.
//    choice=0 -> DISC, k<=0, acc<=0. choice is ignored outside IDLE.
//  - GEN: each edge writes pixel[k] = clamp(mul(in_1,WX[k]) + mul(in_2,WC[k]), 0, 1.0), then k++.
//    At k=8: write, go to IDLE, gen_finish<=1 for exactly one cycle.
//    Start edge E0 -> pixels written E1..E9 -> gen_finish high E9..E10.
//    in_1/in_2 must be held stable for the whole operation.
//  - Weights: WX = +1.0 at corners and centre (1x1,1x3,2x2,3x1,3x3), -1.0 elsewhere.
//    WC = +1.0 on the 8 border pixels, -1.0 at centre.
//  - DISC: each edge acc += mul(pixel[k], WD[k]); at k=8 go to DFIN.
//    WD: corners +0.25, edge-midpoints +0.125, centre +0.5.
//  - DFIN: out_discriminator <= clamp(acc - 0.5, 0, 1.0); disc_finish<=1 for one cycle; go to IDLE.
//    Start E0 -> accumulate E1..E9 -> out written E10.
//  - Outputs hold their values between operations. Pixels change only in GEN;
//    out_discriminator changes only in DFIN.
//  - mul(a,b): signed 32x32 -> 64 product, result = bits [55:24] (floor).
//  - Pixel sum is computed at 34 bits before clamping. Accumulator is a 40-bit signed value.
//    Clamp: negative -> 0, greater than 0x01000000 -> 0x01000000.
//  - Back-to-back: after any finish pulse the FSM is in IDLE and samples choice on the next edge.
// TESTING
//  1 Reset held 2 cycles -> all pixels 0, out_discriminator 0, both finish pulses 0.
//  2 in_1=0, in_2=0x01000000, choice=1 one cycle -> after gen_finish: border pixels 0x01000000,
//    pixel_2x2=0. Then choice=0 -> disc_finish, out_discriminator=0x01000000.
//  3 in_1=0x01000000, in_2=0, choice=1 -> cross: corners and centre 0x01000000, others 0.
//    Then DISC -> out_discriminator=0x01000000.
//  4 DISC straight after reset (all-zero image) -> acc=-0.5, clamped,
//    out_discriminator=0, disc_finish pulses at E10.
//  5 in_1=in_2=0x01000000 -> corners 0x01000000 (sum 2.0 clamped); edge-midpoints 0; centre 0.
//    Checks the clamp and the floor behaviour of mul().
//  6 Assert rst during GEN at k=4 -> all outputs return to 0 and no finish pulse occurs.
//    choice is ignored while busy; gen_finish pulse width is exactly 1 cycle.

Source files
------------

// File: rtl/top_level.sv
// Fixed-weight GAN datapath: 3x3 cross/circle generator plus a scoring
// discriminator, Q8.24 signed, one multiply-accumulate per clock.
module top_level #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             choice,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             gen_finish,
  output logic             disc_finish,
  output logic [WIDTH-1:0] out_discriminator,
  output logic [WIDTH-1:0] pixel_1x1,
  output logic [WIDTH-1:0] pixel_1x2,
  output logic [WIDTH-1:0] pixel_1x3,
  output logic [WIDTH-1:0] pixel_2x1,
  output logic [WIDTH-1:0] pixel_2x2,
  output logic [WIDTH-1:0] pixel_2x3,
  output logic [WIDTH-1:0] pixel_3x1,
  output logic [WIDTH-1:0] pixel_3x2,
  output logic [WIDTH-1:0] pixel_3x3
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] DISC = 2'd2;
  localparam logic [1:0] DFIN = 2'd3;

  localparam logic [WIDTH-1:0] ONE     = 32'h0100_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFF00_0000;
  localparam logic [WIDTH-1:0] HALF    = 32'h0080_0000;
  localparam logic [WIDTH-1:0] QUARTER = 32'h0040_0000;
  localparam logic [WIDTH-1:0] EIGHTH  = 32'h0020_0000;

  localparam logic signed [39:0] ONE40  = 40'sh00_0100_0000;
  localparam logic signed [39:0] HALF40 = 40'sh00_0080_0000;

  function automatic logic [WIDTH-1:0] mul(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [63:0] p;
    p = a * b;
    return 32'(p >>> 24);
  endfunction

  function automatic logic [WIDTH-1:0] clamp(
    input logic signed [39:0] v
  );
    if (v < 0)
      return '0;
    else if (v > ONE40)
      return ONE;
    else
      return 32'(v);
  endfunction

  function automatic logic [WIDTH-1:0] wx(input logic [3:0] k);
    unique case (k)
      4'd0, 4'd2, 4'd4, 4'd6, 4'd8: return ONE;
      default:                      return NEG_ONE;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] wc(input logic [3:0] k);
    return (k == 4'd4) ? NEG_ONE : ONE;
  endfunction

  function automatic logic [WIDTH-1:0] wd(input logic [3:0] k);
    unique case (k)
      4'd0, 4'd2, 4'd6, 4'd8: return QUARTER;
      4'd4:                   return HALF;
      default:                return EIGHTH;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic signed [39:0] acc_q, acc_d;
  logic [WIDTH-1:0]  pix_q [9];
  logic [WIDTH-1:0]  pix_d [9];
  logic [WIDTH-1:0]  out_q, out_d;
  logic              gen_q, gen_d;
  logic              disc_q, disc_d;

  logic [WIDTH-1:0]   m1, m2, dp;
  logic signed [33:0] gen_sum;
  logic signed [39:0] disc_term;

  // Sum kept at 34 bits so 2.0 or -2.0 cannot wrap before the clamp.
  assign m1        = mul(in_1, wx(k_q));
  assign m2        = mul(in_2, wc(k_q));
  assign gen_sum   = {{2{m1[31]}}, m1} + {{2{m2[31]}}, m2};
  assign dp        = mul(pix_q[k_q], wd(k_q));
  assign disc_term = {{8{dp[31]}}, dp};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    pix_d   = pix_q;
    out_d   = out_q;
    gen_d   = 1'b0;
    disc_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (choice) begin
          state_d = GEN;
        end else begin
          state_d = DISC;
          acc_d   = '0;
        end
      end
      GEN: begin
        pix_d[k_q] = clamp({{6{gen_sum[33]}}, gen_sum});
        k_d        = k_q + 4'd1;
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = IDLE;
          gen_d   = 1'b1;
        end
      end
      DISC: begin
        acc_d = acc_q + disc_term;
        k_d   = k_q + 4'd1;
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = DFIN;
        end
      end
      DFIN: begin
        out_d   = clamp(acc_q - HALF40);
        disc_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      pix_q   <= '{default: '0};
      out_q   <= '0;
      gen_q   <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      gen_q   <= gen_d;
      disc_q  <= disc_d;
    end
  end

  assign gen_finish        = gen_q;
  assign disc_finish       = disc_q;
  assign out_discriminator = out_q;
  assign pixel_1x1 = pix_q[0];
  assign pixel_1x2 = pix_q[1];
  assign pixel_1x3 = pix_q[2];
  assign pixel_2x1 = pix_q[3];
  assign pixel_2x2 = pix_q[4];
  assign pixel_2x3 = pix_q[5];
  assign pixel_3x1 = pix_q[6];
  assign pixel_3x2 = pix_q[7];
  assign pixel_3x3 = pix_q[8];

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: generator images, discriminator scores,
// latencies, pulse widths and reset abort.
module tb_top_level;

  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        choice = 1'b0;
  logic [31:0] in_1 = '0;
  logic [31:0] in_2 = '0;
  logic        gen_finish, disc_finish;
  logic [31:0] out_d;
  logic [31:0] pix [9];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  top_level #(.WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .choice            (choice),
    .in_1              (in_1),
    .in_2              (in_2),
    .gen_finish        (gen_finish),
    .disc_finish       (disc_finish),
    .out_discriminator (out_d),
    .pixel_1x1         (pix[0]),
    .pixel_1x2         (pix[1]),
    .pixel_1x3         (pix[2]),
    .pixel_2x1         (pix[3]),
    .pixel_2x2         (pix[4]),
    .pixel_2x3         (pix[5]),
    .pixel_3x1         (pix[6]),
    .pixel_3x2         (pix[7]),
    .pixel_3x3         (pix[8])
  );

  task automatic run_gen(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e [9], input string nm);
    int n;
    in_1   = a;
    in_2   = b;
    choice = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gen_finish !== 1'b0 || disc_finish !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: gen=%b disc=%b required 0 0",
               nm, gen_finish, disc_finish);
    end
    // Dropping choice mid-run must not divert the generator.
    choice = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (gen_finish) break;
    end
    checks++;
    if (n !== 9 || gen_finish !== 1'b1) begin
      errors++;
      $display("FAIL %s gen_latency: got %0d edges required 9", nm, n);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (pix[i] !== e[i]) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got %h required %h", nm, i, pix[i], e[i]);
      end
    end
  endtask

  task automatic run_disc(input logic [31:0] e, input string nm);
    int n;
    choice = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (gen_finish !== 1'b0 || disc_finish !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: gen=%b disc=%b required 0 0",
               nm, gen_finish, disc_finish);
    end
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (disc_finish) break;
    end
    checks++;
    if (n !== 10 || disc_finish !== 1'b1) begin
      errors++;
      $display("FAIL %s disc_latency: got %0d edges required 10", nm, n);
    end
    checks++;
    if (out_d !== e) begin
      errors++;
      $display("FAIL %s score: got %h required %h", nm, out_d, e);
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (gen_finish !== 1'b0 || disc_finish !== 1'b0 || out_d !== 32'h0) begin
      errors++;
      $display("FAIL %s ctl: gen=%b disc=%b score=%h required 0 0 0",
               nm, gen_finish, disc_finish, out_d);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (pix[i] !== 32'h0) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got %h required 0", nm, i, pix[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_disc_empty;
    run_disc(32'h0, "disc_empty");
  endtask

  task automatic test_circle;
    logic [31:0] e [9];
    e = '{ONE, ONE, ONE, ONE, 32'h0, ONE, ONE, ONE, ONE};
    run_gen(32'h0, ONE, e, "circle");
    run_disc(ONE, "circle_disc");
  endtask

  task automatic test_cross;
    logic [31:0] e [9];
    e = '{ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, ONE};
    run_gen(ONE, 32'h0, e, "cross");
    run_disc(ONE, "cross_disc");
  endtask

  task automatic test_clamp;
    logic [31:0] e [9];
    e = '{ONE, 32'h0, ONE, 32'h0, 32'h0, 32'h0, ONE, 32'h0, ONE};
    run_gen(ONE, ONE, e, "clamp");
    run_disc(32'h0080_0000, "clamp_disc");
  endtask

  task automatic test_fraction;
    logic [31:0] e [9];
    logic [31:0] c;
    c = 32'h00C0_0000;
    e = '{c, 32'h0, c, 32'h0, 32'h0040_0000, 32'h0, c, 32'h0, c};
    run_gen(32'h0080_0000, 32'h0040_0000, e, "fraction");
    run_disc(32'h0060_0000, "fraction_disc");
  endtask

  task automatic test_back_to_back;
    logic [31:0] e [9];
    e = '{ONE, ONE, ONE, ONE, 32'h0, ONE, ONE, ONE, ONE};
    run_gen(32'h0, ONE, e, "b2b_gen1");
    e = '{ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, ONE};
    run_gen(ONE, 32'h0, e, "b2b_gen2");
  endtask

  task automatic test_reset_mid_gen;
    int seen;
    in_1   = ONE;
    in_2   = ONE;
    choice = 1'b1;
    @(posedge clk); #1;
    choice = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("reset_mid");
    seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (gen_finish) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid no_gen_finish: got %0d pulses required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_disc_empty();
    test_circle();
    test_cross();
    test_clamp();
    test_fraction();
    test_back_to_back();
    test_reset_mid_gen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
